// File: rtl/fft_frame_streamer.sv
// Ring-buffered audio framer feeding the FFT input AXI-stream.
// Every HOP samples the newest N samples are streamed oldest first, one beat per clock.
module fft_frame_streamer #(
    parameter int K_WIDTH      = 11,
    parameter int SAMPLE_WIDTH = 16,
    parameter int HOP          = 512
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [SAMPLE_WIDTH-1:0]   sample_in,
    input  logic                      sample_valid,
    output logic [2*SAMPLE_WIDTH-1:0] fft_tdata,
    output logic                      fft_tvalid,
    input  logic                      fft_tready,
    output logic                      fft_tlast,
    output logic [K_WIDTH-1:0]        fft_tuser,
    output logic                      frame_start,
    output logic                      overrun
);

    localparam int N     = 1 << K_WIDTH;
    localparam int AW    = K_WIDTH + 1;
    localparam int DEPTH = 2 * N;
    localparam int HW    = (HOP > 1) ? $clog2(HOP) : 1;

    localparam logic [AW-1:0]      N_PTR    = AW'(N);
    localparam logic [AW-1:0]      FILL_M1  = AW'(N - 1);
    localparam logic [HW-1:0]      HOP_LAST = HW'(HOP - 1);
    localparam logic [K_WIDTH-1:0] IDX_LAST = '1;

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] sample;
        logic [K_WIDTH-1:0]      idx;
    } beat_t;

    // write side
    logic [AW-1:0] wr_ptr, wr_ptr_nxt, trig_ptr;
    logic [AW-1:0] fill_cnt;
    logic [HW-1:0] hop_cnt;
    logic          hop_wrap, trigger;

    // frame control
    logic [1:0]         state, state_nxt;
    logic [AW-1:0]      start_ptr, start_nxt;
    logic [AW-1:0]      pend_ptr, pend_ptr_nxt;
    logic               pending, pend_nxt, ovr_nxt;
    logic               begin_frame;
    logic [K_WIDTH-1:0] rd_idx, rd_idx_q;
    logic               issue_done, rd_issue, rd_vld;
    logic [AW-1:0]      rd_addr;

    // storage and output stage
    logic [SAMPLE_WIDTH-1:0] ram [DEPTH];
    logic [SAMPLE_WIDTH-1:0] rd_data;
    beat_t                   rd_beat, out_q, skid_q, load_beat;
    logic                    out_vld, skid_vld, pop, load_out, last_hs, room;
    logic [1:0]              occ;

    assign hop_wrap   = (hop_cnt == HOP_LAST);
    assign wr_ptr_nxt = wr_ptr + AW'(1);
    assign trig_ptr   = wr_ptr_nxt - N_PTR;
    assign trigger    = sample_valid &&
                        ((fill_cnt == FILL_M1) || ((fill_cnt == N_PTR) && hop_wrap));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            fill_cnt <= '0;
            hop_cnt  <= '0;
        end else if (sample_valid) begin
            wr_ptr  <= wr_ptr_nxt;
            hop_cnt <= hop_wrap ? '0 : hop_cnt + 1'b1;
            if (fill_cnt != N_PTR)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // Read-before-write: a read colliding with a write returns the old sample.
    always_ff @(posedge clock) begin
        if (sample_valid)
            ram[wr_ptr] <= sample_in;
        if (rd_issue)
            rd_data <= ram[rd_addr];
    end

    always_comb begin
        state_nxt    = state;
        start_nxt    = start_ptr;
        pend_nxt     = pending;
        pend_ptr_nxt = pend_ptr;
        ovr_nxt      = overrun;
        begin_frame  = 1'b0;
        case (state)
            S_FILL: begin
                if (trigger) begin
                    state_nxt   = S_STREAM;
                    start_nxt   = trig_ptr;
                    begin_frame = 1'b1;
                end
            end
            S_IDLE: begin
                if (trigger) begin
                    state_nxt   = S_STREAM;
                    start_nxt   = trig_ptr;
                    pend_nxt    = 1'b0;
                    begin_frame = 1'b1;
                end else if (pending) begin
                    state_nxt   = S_STREAM;
                    start_nxt   = pend_ptr;
                    pend_nxt    = 1'b0;
                    begin_frame = 1'b1;
                end
            end
            S_STREAM: begin
                // A trigger landing on the tlast beat is folded in before deciding what follows.
                if (trigger) begin
                    if (pending)
                        ovr_nxt = 1'b1;
                    pend_nxt     = 1'b1;
                    pend_ptr_nxt = trig_ptr;
                end
                if (last_hs) begin
                    if (pend_nxt) begin
                        start_nxt   = pend_ptr_nxt;
                        pend_nxt    = 1'b0;
                        begin_frame = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_FILL;
            start_ptr <= '0;
            pend_ptr  <= '0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_ptr <= start_nxt;
            pend_ptr  <= pend_ptr_nxt;
            pending   <= pend_nxt;
            overrun   <= ovr_nxt;
        end
    end

    // Items held or in flight after this cycle's pop must not exceed out + skid.
    assign pop      = out_vld & fft_tready;
    assign occ      = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld};
    assign room     = (occ < 2'd2) || (pop && (occ == 2'd2));
    assign rd_issue = (state == S_STREAM) && !issue_done && room;
    assign rd_addr  = start_ptr + {1'b0, rd_idx};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_idx     <= '0;
            rd_idx_q   <= '0;
            issue_done <= 1'b0;
            rd_vld     <= 1'b0;
        end else begin
            rd_vld <= rd_issue;
            if (rd_issue)
                rd_idx_q <= rd_idx;
            if (begin_frame) begin
                rd_idx     <= '0;
                issue_done <= 1'b0;
            end else if (rd_issue) begin
                rd_idx <= rd_idx + 1'b1;
                if (rd_idx == IDX_LAST)
                    issue_done <= 1'b1;
            end
        end
    end

    // The skid only ever fills while out is held, so it never coexists with rd_vld.
    always_comb begin
        rd_beat.sample = rd_data;
        rd_beat.idx    = rd_idx_q;
        load_beat      = skid_vld ? skid_q : rd_beat;
        load_out       = (skid_vld && pop) || (!skid_vld && rd_vld && (!out_vld || pop));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_vld     <= 1'b0;
            out_q       <= '0;
            skid_vld    <= 1'b0;
            skid_q      <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= load_out && (load_beat.idx == '0);
            out_vld     <= load_out | (out_vld & ~pop);
            if (load_out)
                out_q <= load_beat;
            if (skid_vld && pop) begin
                skid_vld <= 1'b0;
            end else if (rd_vld && out_vld && !pop) begin
                skid_vld <= 1'b1;
                skid_q   <= rd_beat;
            end
        end
    end

    assign last_hs    = pop && (out_q.idx == IDX_LAST);
    assign fft_tvalid = out_vld;
    assign fft_tdata  = {{SAMPLE_WIDTH{1'b0}}, out_q.sample};
    assign fft_tuser  = out_q.idx;
    assign fft_tlast  = out_vld && (out_q.idx == IDX_LAST);

endmodule
